// File: rtl/sq_iter.sv
// Iterative shift-add squarer: one partial product per clock.
// The 2*IN_W-bit result is held until the downstream side accepts it.
module sq_iter #(
    parameter int IN_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      sq_i,
    input  logic                 val_i,
    output logic                 rdy_o,
    output logic [2*IN_W-1:0]    sq_o,
    output logic                 val_o,
    input  logic                 rdy_i,
    output logic [CNT_W-1:0]     done_cnt_o
);

    localparam int OUT_W = 2 * IN_W;
    localparam int IT_W  = $clog2(IN_W);
    localparam logic [IT_W-1:0] LAST_IT = IT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_mcand;
    logic [IN_W-1:0]    r_mplier;
    logic [OUT_W-1:0]   r_acc;
    logic [IT_W-1:0]    r_iter;
    logic [OUT_W-1:0]   r_sq;
    logic               r_val;
    logic [CNT_W-1:0]   r_cnt;

    logic [OUT_W-1:0]   w_addend;
    logic [OUT_W-1:0]   w_sum;
    logic               w_last;

    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + w_addend;
    assign w_last   = (r_iter == LAST_IT);

    // Ready is a pure state decode, held low while reset is asserted.
    assign rdy_o      = (r_state == IDLE) & ~rst;
    assign sq_o       = r_sq;
    assign val_o      = r_val;
    assign done_cnt_o = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_iter   <= '0;
            r_sq     <= '0;
            r_val    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (val_i) begin
                        r_mcand  <= {{IN_W{1'b0}}, sq_i};
                        r_mplier <= sq_i;
                        r_acc    <= '0;
                        r_iter   <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        r_iter  <= '0;
                        r_sq    <= w_sum;
                        r_val   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                DONE: begin
                    if (rdy_i) begin
                        r_val   <= 1'b0;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_val   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sq_iter.md
Name: sq_iter

Overview:
Iterative shift-add squarer, the inverse of the sqrt_lut path: takes an IN_W-bit root and returns its exact 2*IN_W-bit square.
- Used to regenerate square values from sqrt_lut outputs, so a bench can check the round trip floor(sqrt(x)) and x-domain consistency.
- Also serves as a low-area squarer in the datapath.
- Valid/ready handshake on both sides; computes one partial product per clock.

Parameters:
IN_W, 8, operand width in bits; must be >= 2.
CNT_W, 16, width of the completed-result counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
sq_i  in  IN_W  operand (root value)
val_i  in  1  operand valid
rdy_o  out  1  block can accept an operand this cycle
sq_o  out  2*IN_W  square result, unsigned
val_o  out  1  result valid
rdy_i  in  1  downstream accepts result
done_cnt_o  out  CNT_W  number of results consumed since reset

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE
  - sq_o=0, val_o=0, rdy_o=1 after deassertion (rdy_o=0 while rst high)
  - done_cnt_o=0
  - internal multiplicand, multiplier, accumulator and iteration counter all cleared
- Reset mid-operation: the in-flight operand is discarded and no val_o pulse is produced for it.
- States: IDLE, CALC, DONE. All outputs are registered or decoded directly from state; there is no combinational path from val_i or rdy_i to any output.
- IDLE:
  - rdy_o=1.
  - On val_i=1 at an edge: mcand<=zero-extended sq_i (2*IN_W bits), mplier<=sq_i, acc<=0, iter<=0, state<=CALC.
  - val_i=0 leaves state in IDLE.
- CALC:
  - rdy_o=0; val_i is ignored, and a held val_i is not consumed.
  - Each edge: acc<=acc+(mplier[0] ? mcand : 0); mcand<=mcand<<1; mplier<=mplier>>1; iter<=iter+1.
  - When iter==IN_W-1 at an edge, that edge performs the last add, loads sq_o with the final sum, sets val_o<=1 and moves state to DONE.
  - Exactly IN_W iterations run; there is no early exit on a zero multiplier.
- Width rule: acc and sq_o are 2*IN_W bits. The maximum (2^IN_W-1)^2 fits, so overflow never occurs.
- Latency: the operand is accepted at edge k; val_o=1 is visible after edge k+IN_W (8 clocks at default).
- DONE:
  - val_o=1; sq_o holds stable while rdy_i=0 (any number of cycles).
  - On rdy_i=1 at an edge: val_o<=0, done_cnt_o<=done_cnt_o+1, state<=IDLE.
- Throughput: one result per IN_W+2 cycles with no backpressure (IN_W in CALC, 1 in DONE, 1 in IDLE).
- rdy_i is sampled only in DONE.
- done_cnt_o wraps modulo 2^CNT_W without a flag.
- Operand 0: runs the full IN_W iterations and produces sq_o=0 with val_o asserted normally.

Test Plan:
1. Reset then sq_i=8'd255, val_i pulse, rdy_i=1 -> val_o high exactly 8 clocks after the accept edge, sq_o=16'd65025, one cycle wide; done_cnt_o=1.
2. sq_i=0 then sq_i=1 then sq_i=16, each held until accepted -> sq_o=0, 1, 256 in order. No val_o is lost; val_o rises IN_W+2 cycles apart; done_cnt_o=3.
3. Backpressure: sq_i=8'd200 accepted, rdy_i=0 for 20 cycles after val_o rises -> sq_o=16'd40000 and val_o=1 stable all 20 cycles, rdy_o=0, done_cnt_o unchanged. Then rdy_i=1 -> val_o falls next edge, rdy_o=1.
4. val_i held high with a new value during CALC -> rdy_o=0, the new value is not captured. It is accepted on the first IDLE cycle and its square is correct.
5. Reset mid-CALC: assert rst 4 cycles after accepting sq_i=8'd77 -> val_o, sq_o and done_cnt_o read 0 immediately (async). No result for 77 ever appears; the next operand 8'd3 yields 9.
6. Round-trip stream: feed all sqrt_lut outputs r (0..255) with random rdy_i stalls -> every sq_o==r*r. Scoreboard: r*r <= x < (r+1)*(r+1) for the matching sqrt_lut input x. done_cnt_o equals the result count.
